bp_fe_queue_pairer: RTL

Front-end block that packs the single-instruction fetch stream into the dual-slot FE queue interface consumed by the dual-issue back end. Fetch packets (instructions or FE exceptions) are staged in a one-entry hold register and paired with the next contiguous instruction when possible. Lone instructions are emitted single after a timeout. The output is a registered valid/ready pair; slot 1 is always the older packet.

---
 rtl/bp_fe_pkg.sv | 56 +++++
 rtl/bp_fe_pair_out_reg.sv | 43 ++++
 rtl/bp_fe_queue_pairer.sv | 111 +++++++++++
 3 files changed

// File: rtl/bp_fe_pkg.sv
// Shared front-end types: fetch-queue packet layout, pairer state and PC step.
`ifndef BP_FE_PKG_DEFS
`define BP_FE_PKG_DEFS
`define BP_FE_QUEUE_WIDTH(vaddr_width_mp, branch_metadata_fwd_width_mp) \
    (1 + (vaddr_width_mp) + 32 + (branch_metadata_fwd_width_mp))
`endif

package bp_fe_pkg;

    typedef enum logic {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned bp_vaddr_width               = 39;
    localparam int unsigned bp_branch_metadata_fwd_width = 36;
    localparam int unsigned bp_instr_width               = 32;
    localparam int unsigned bp_exception_code_width      = 4;
    localparam int unsigned bp_exception_pad_width       =
        bp_instr_width + bp_branch_metadata_fwd_width - bp_exception_code_width;

    // Byte distance between consecutive sequential instructions
    localparam int unsigned bp_pc_step = 4;

    typedef enum logic {
        e_pair_empty = 1'b0,
        e_pair_hold  = 1'b1
    } bp_fe_pair_state_e;

    typedef enum logic {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef struct packed {
        logic [bp_vaddr_width-1:0]               pc;
        logic [bp_instr_width-1:0]               instr;
        logic [bp_branch_metadata_fwd_width-1:0] branch_metadata_fwd;
    } bp_fe_fetch_s;

    typedef struct packed {
        logic [bp_vaddr_width-1:0]          vaddr;
        logic [bp_exception_code_width-1:0] exception_code;
        logic [bp_exception_pad_width-1:0]  padding;
    } bp_fe_exception_s;

    typedef union packed {
        bp_fe_fetch_s     fetch;
        bp_fe_exception_s exception;
    } bp_fe_msg_u;

    typedef struct packed {
        bp_fe_queue_type_e msg_type;
        bp_fe_msg_u        msg;
    } bp_fe_queue_s;

endpackage

// File: rtl/bp_fe_pair_out_reg.sv
// Two-slot FE queue output register; slot 1 holds the older packet.
module bp_fe_pair_out_reg
    import bp_fe_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         load,
    input  logic         load_pair,
    input  bp_fe_queue_s slot1_next,
    input  bp_fe_queue_s slot2_next,
    input  logic         ready,
    output bp_fe_queue_s slot1,
    output bp_fe_queue_s slot2,
    output logic         v1,
    output logic         v2,
    output logic         free_c
);

    // Loads only happen when free, so contents hold steady while stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot1 <= '0;
            slot2 <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (load) begin
            slot1 <= slot1_next;
            slot2 <= load_pair ? slot2_next : bp_fe_queue_s'('0);
            v1    <= 1'b1;
            v2    <= load_pair;
        end else if (ready) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end
    end

    assign free_c = ~v1 | ready;

endmodule

// File: rtl/bp_fe_queue_pairer.sv
// Packs single fetch packets into dual-slot FE queue entries.
// Optional macro BP_FE_PAIRER_PC_CHECK_EN: pair only PC-contiguous fetches.
module bp_fe_queue_pairer
    import bp_fe_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned timeout_p   = 4,
    localparam int unsigned vaddr_width_p               = bp_vaddr_width,
    localparam int unsigned branch_metadata_fwd_width_p = bp_branch_metadata_fwd_width,
    localparam int unsigned fe_queue_width_lp =
        `BP_FE_QUEUE_WIDTH(vaddr_width_p, branch_metadata_fwd_width_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_queue_width_lp-1:0] fetch_i,
    input  logic                         fetch_v_i,
    output logic                         fetch_ready_o,
    input  logic                         flush_i,
    output logic [fe_queue_width_lp-1:0] fe_queue1_o,
    output logic [fe_queue_width_lp-1:0] fe_queue2_o,
    output logic                         fe_queue_v1_o,
    output logic                         fe_queue_v2_o,
    input  logic                         fe_queue_ready_i
);

    localparam int unsigned cnt_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0] timeout_lp = cnt_width_lp'(timeout_p);

    if ((bp_params_p != e_bp_default_cfg) || (fe_queue_width_lp != $bits(bp_fe_queue_s))) begin : g_cfg_err
        $error("bp_fe_queue_pairer: unsupported configuration");
    end

    bp_fe_queue_s             fetch_s;
    bp_fe_queue_s             hold_r;
    bp_fe_queue_s             out1;
    bp_fe_queue_s             out2;
    bp_fe_pair_state_e        state_r;
    logic [cnt_width_lp-1:0]  wait_cnt_r;

    logic hold_v;
    logic out_free;
    logic acc;
    logic pairable;
    logic timed_out;
    logic emit_pair;
    logic emit_single;
    logic emit;
    logic load_hold;

    assign fetch_s       = bp_fe_queue_s'(fetch_i);
    assign hold_v        = (state_r == e_pair_hold);
    assign fetch_ready_o = reset_n_i & ~flush_i & (~hold_v | out_free);
    assign acc           = fetch_v_i & fetch_ready_o;

`ifdef BP_FE_PAIRER_PC_CHECK_EN
    logic [vaddr_width_p-1:0] next_pc;
    assign next_pc  = hold_r.msg.fetch.pc + vaddr_width_p'(bp_pc_step);
    assign pairable = (hold_r.msg_type == e_fe_fetch)
                    & (fetch_s.msg_type == e_fe_fetch)
                    & (fetch_s.msg.fetch.pc == next_pc);
`else
    assign pairable = (hold_r.msg_type == e_fe_fetch)
                    & (fetch_s.msg_type == e_fe_fetch);
`endif

    // Exceptions never wait for a partner; instructions wait up to timeout_p idle cycles
    assign timed_out   = (hold_r.msg_type == e_fe_exception) | (wait_cnt_r == timeout_lp);
    assign emit_pair   = hold_v & out_free & acc & pairable;
    assign emit_single = hold_v & out_free & (acc ? ~pairable : timed_out);
    assign emit        = emit_pair | emit_single;
    assign load_hold   = acc & (~hold_v | ~pairable);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= e_pair_empty;
            hold_r     <= '0;
            wait_cnt_r <= '0;
        end else if (flush_i) begin
            state_r    <= e_pair_empty;
            wait_cnt_r <= '0;
        end else if (load_hold) begin
            state_r    <= e_pair_hold;
            hold_r     <= fetch_s;
            wait_cnt_r <= '0;
        end else if (emit) begin
            state_r <= e_pair_empty;
        end else if (hold_v && (wait_cnt_r != timeout_lp)) begin
            wait_cnt_r <= wait_cnt_r + cnt_width_lp'(1);
        end
    end

    bp_fe_pair_out_reg out_reg (
        .clk        (clk_i),
        .reset_n    (reset_n_i),
        .flush      (flush_i),
        .load       (emit),
        .load_pair  (emit_pair),
        .slot1_next (hold_r),
        .slot2_next (fetch_s),
        .ready      (fe_queue_ready_i),
        .slot1      (out1),
        .slot2      (out2),
        .v1         (fe_queue_v1_o),
        .v2         (fe_queue_v2_o),
        .free_c     (out_free)
    );

    assign fe_queue1_o = out1;
    assign fe_queue2_o = out2;

endmodule
